sudoku_board_arbiter: RTL and testbench

SUDOKU_BOARD_ARBITER -- requirements
Module: sudoku_board_arbiter

---
 rtl/sudoku_board_arbiter_if.sv | 34 +++
 rtl/sudoku_board_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_sudoku_board_arbiter.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sudoku_board_arbiter_if.sv
// Write-port bundle for the sudoku board: two requesters (A = mouse placement,
// B = recognizer) plus the clear-board control and its busy status.
interface sudoku_board_arbiter_if;
  logic       a_req;
  logic [3:0] a_row;
  logic [3:0] a_col;
  logic [3:0] a_val;
  logic       a_gnt;

  logic       b_req;
  logic [3:0] b_row;
  logic [3:0] b_col;
  logic [3:0] b_val;
  logic       b_gnt;

  logic       clr_board;
  logic       busy;

  // Requester side
  modport master (
    output a_req, a_row, a_col, a_val,
    output b_req, b_row, b_col, b_val,
    output clr_board,
    input  a_gnt, b_gnt, busy
  );

  // Board side
  modport slave (
    input  a_req, a_row, a_col, a_val,
    input  b_req, b_row, b_col, b_val,
    input  clr_board,
    output a_gnt, b_gnt, busy
  );
endinterface

// File: rtl/sudoku_board_arbiter.sv
// Sudoku board store: 81 x 4-bit cells written by two round-robin arbitrated
// requesters or a sequential clear, and read continuously by a 2-stage VGA
// render pipeline that produces glyph ROM address/select per pixel.
module sudoku_board_arbiter #(
  parameter int unsigned CELL = 52,
  parameter int unsigned X0   = 86,
  parameter int unsigned Y0   = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  sudoku_board_arbiter_if.slave bus,
  input  logic [9:0]            h_cnt,
  input  logic [9:0]            v_cnt,
  input  logic                  valid,
  output logic [11:0]           glyph_addr,
  output logic [3:0]            glyph_sel,
  output logic                  glyph_en
);

  localparam int unsigned BoardPx = 9 * CELL;
  localparam int unsigned OffW    = (CELL > 1) ? $clog2(CELL) : 1;

  typedef enum logic [0:0] {StIdle, StClear} state_e;

  state_e     state_q;
  logic       ptr_b_q;    // 0: A wins a tie, 1: B wins a tie
  logic [6:0] clr_idx_q;
  logic       busy_q;
  logic       a_gnt_q;
  logic       b_gnt_q;
  logic [3:0] board_q [81];

  // ---------------------------------------------------------------------------
  // Request decode and arbitration
  // ---------------------------------------------------------------------------
  logic       a_ok;
  logic       b_ok;
  logic [6:0] a_idx;
  logic [6:0] b_idx;
  logic       pick_a;
  logic       pick_b;

  // Range-check requests, form cell indices and pick the round-robin winner
  always_comb begin
    a_ok   = (bus.a_row <= 4'd8) && (bus.a_col <= 4'd8) && (bus.a_val <= 4'd9);
    b_ok   = (bus.b_row <= 4'd8) && (bus.b_col <= 4'd8) && (bus.b_val <= 4'd9);
    a_idx  = 7'(bus.a_row) * 7'd9 + 7'(bus.a_col);
    b_idx  = 7'(bus.b_row) * 7'd9 + 7'(bus.b_col);
    pick_a = bus.a_req && (!bus.b_req || !ptr_b_q);
    pick_b = bus.b_req && !pick_a;
  end

  // Control FSM: grants and board writes in idle, one-cell-per-cycle clear
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= StIdle;
      ptr_b_q   <= 1'b0;
      clr_idx_q <= 7'd0;
      busy_q    <= 1'b0;
      a_gnt_q   <= 1'b0;
      b_gnt_q   <= 1'b0;
      for (int i = 0; i < 81; i++) begin
        board_q[i] <= 4'd0;
      end
    end else begin
      a_gnt_q <= 1'b0;
      b_gnt_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (bus.clr_board) begin
            // Clear takes precedence; pending requests wait until it finishes
            state_q   <= StClear;
            busy_q    <= 1'b1;
            clr_idx_q <= 7'd0;
          end else if (pick_a) begin
            a_gnt_q <= 1'b1;
            ptr_b_q <= 1'b1;
            if (a_ok) begin
              board_q[a_idx] <= bus.a_val;
            end
          end else if (pick_b) begin
            b_gnt_q <= 1'b1;
            ptr_b_q <= 1'b0;
            if (b_ok) begin
              board_q[b_idx] <= bus.b_val;
            end
          end
        end
        StClear: begin
          board_q[clr_idx_q] <= 4'd0;
          if (clr_idx_q == 7'd80) begin
            state_q   <= StIdle;
            busy_q    <= 1'b0;
            clr_idx_q <= 7'd0;
          end else begin
            clr_idx_q <= clr_idx_q + 7'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.a_gnt = a_gnt_q;
  assign bus.b_gnt = b_gnt_q;
  assign bus.busy  = busy_q;

  // ---------------------------------------------------------------------------
  // Render pipeline
  // ---------------------------------------------------------------------------
  logic [31:0] dx;
  logic [31:0] dy;
  logic [31:0] x_c;
  logic [31:0] y_c;
  logic [3:0]  col_c;
  logic [3:0]  row_c;
  logic        in_c;

  // Pixel to cell/offset via a compare chain (cell count is fixed at 9)
  always_comb begin
    dx    = 32'(h_cnt) - X0;
    dy    = 32'(v_cnt) - Y0;
    col_c = 4'd0;
    row_c = 4'd0;
    x_c   = dx;
    y_c   = dy;
    for (int unsigned i = 1; i < 9; i++) begin
      if (dx >= i * CELL) begin
        col_c = 4'(i);
        x_c   = dx - i * CELL;
      end
      if (dy >= i * CELL) begin
        row_c = 4'(i);
        y_c   = dy - i * CELL;
      end
    end
    in_c = (32'(h_cnt) >= X0) && (32'(h_cnt) < X0 + BoardPx) &&
           (32'(v_cnt) >= Y0) && (32'(v_cnt) < Y0 + BoardPx);
  end

  logic [3:0]      s1_col;
  logic [3:0]      s1_row;
  logic [OffW-1:0] s1_x;
  logic [OffW-1:0] s1_y;
  logic            s1_in;
  logic            s1_valid;

  logic [6:0]  s1_idx;
  logic [3:0]  cell_val;
  logic [31:0] addr_c;
  logic        en_c;

  // Stage-2 lookup; the chain caps row/col at 8 so the index stays in range
  always_comb begin
    s1_idx   = 7'(s1_row) * 7'd9 + 7'(s1_col);
    cell_val = board_q[s1_idx];
    addr_c   = 32'(s1_y) * CELL + 32'(s1_x);
    en_c     = s1_in && s1_valid && (cell_val != 4'd0);
  end

  // Two pipeline stages: register geometry, then register glyph outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_col     <= 4'd0;
      s1_row     <= 4'd0;
      s1_x       <= '0;
      s1_y       <= '0;
      s1_in      <= 1'b0;
      s1_valid   <= 1'b0;
      glyph_en   <= 1'b0;
      glyph_sel  <= 4'd0;
      glyph_addr <= 12'd0;
    end else begin
      s1_col     <= col_c;
      s1_row     <= row_c;
      s1_x       <= x_c[OffW-1:0];
      s1_y       <= y_c[OffW-1:0];
      s1_in      <= in_c;
      s1_valid   <= valid;
      glyph_en   <= en_c;
      glyph_sel  <= en_c ? cell_val : 4'd0;
      glyph_addr <= en_c ? addr_c[11:0] : 12'd0;
    end
  end

endmodule

// File: tb/tb_sudoku_board_arbiter.sv
// Directed self-checking bench for sudoku_board_arbiter: reset, arbitration,
// out-of-range requests, clear sequence, render pipeline and mid-clear reset.
module tb_sudoku_board_arbiter;
  localparam int CELL = 52;
  localparam int X0   = 86;
  localparam int Y0   = 6;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [9:0]  h_cnt = 10'd0;
  logic [9:0]  v_cnt = 10'd0;
  logic        valid = 1'b0;
  logic [11:0] glyph_addr;
  logic [3:0]  glyph_sel;
  logic        glyph_en;

  sudoku_board_arbiter_if bus ();

  sudoku_board_arbiter #(
    .CELL (CELL),
    .X0   (X0),
    .Y0   (Y0)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .h_cnt      (h_cnt),
    .v_cnt      (v_cnt),
    .valid      (valid),
    .glyph_addr (glyph_addr),
    .glyph_sel  (glyph_sel),
    .glyph_en   (glyph_en)
  );

  always #20 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    int h;
    int v;
    int vl;
    int en;
    int sel;
    int addr;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Issue one request on side A (side_b=0) or B, wait for its grant, drop it
  task automatic write(input bit side_b, input int r, input int c, input int v,
                       input string name);
    int n;
    int g;
    n = 0;
    if (side_b) begin
      bus.b_row = 4'(r); bus.b_col = 4'(c); bus.b_val = 4'(v); bus.b_req = 1'b1;
    end else begin
      bus.a_row = 4'(r); bus.a_col = 4'(c); bus.a_val = 4'(v); bus.a_req = 1'b1;
    end
    do begin
      tick();
      n++;
      g = side_b ? int'(bus.b_gnt) : int'(bus.a_gnt);
    end while (g == 0 && n < 4);
    check({name, "_gnt"}, g, 1);
    check({name, "_lat"}, n, 1);
    bus.a_req = 1'b0;
    bus.b_req = 1'b0;
    tick();
    g = side_b ? int'(bus.b_gnt) : int'(bus.a_gnt);
    check({name, "_pulse"}, g, 0);
  endtask

  // Present one pixel and sample the glyph outputs two cycles later
  task automatic pix(input int h, input int v, input int vl,
                     output int en, output int sel, output int addr);
    h_cnt = 10'(h);
    v_cnt = 10'(v);
    valid = (vl != 0);
    tick();
    tick();
    en   = int'(glyph_en);
    sel  = int'(glyph_sel);
    addr = int'(glyph_addr);
  endtask

  task automatic check_cell(input int r, input int c, input int exp, input string name);
    int en, sel, addr;
    pix(X0 + c * CELL + CELL / 2, Y0 + r * CELL + CELL / 2, 1, en, sel, addr);
    check({name, "_sel"}, sel, exp);
    check({name, "_en"}, en, (exp != 0) ? 1 : 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int en, sel, addr;
    int busy_cnt, gnt_during;

    //            h    v    vl en sel addr
    vecs[0] = '{ 85,   6, 1, 0, 0,    0};  // one pixel left of board
    vecs[1] = '{ 86,   6, 1, 1, 1,    0};  // first board pixel, cell (0,0)
    vecs[2] = '{553,   6, 1, 1, 9,   51};  // last board column, cell (0,8)
    vecs[3] = '{554,   6, 1, 0, 0,    0};  // one pixel right of board
    vecs[4] = '{ 86,   6, 0, 0, 0,    0};  // blanking
    vecs[5] = '{138,   6, 1, 0, 0,    0};  // empty cell (0,1)
    vecs[6] = '{252, 115, 1, 1, 7,  270};  // cell (2,3) x=10 y=5
    vecs[7] = '{293, 161, 1, 1, 7, 2703};  // cell (2,3) x=51 y=51
    vecs[8] = '{252,   5, 1, 0, 0,    0};  // one line above board
    vecs[9] = '{137,  57, 1, 1, 1, 2703};  // cell (0,0) x=51 y=51

    bus.a_req = 1'b1; bus.a_row = 4'd2; bus.a_col = 4'd3; bus.a_val = 4'd7;
    bus.b_req = 1'b1; bus.b_row = 4'd1; bus.b_col = 4'd1; bus.b_val = 4'd1;
    bus.clr_board = 1'b0;

    // Reset with both requests high: nothing may be granted
    rst = 1'b0;
    repeat (3) tick();
    check("rst_a_gnt", int'(bus.a_gnt), 0);
    check("rst_b_gnt", int'(bus.b_gnt), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_glyph_en", int'(glyph_en), 0);
    check("rst_glyph_addr", int'(glyph_addr), 0);
    check("rst_glyph_sel", int'(glyph_sel), 0);
    bus.a_req = 1'b0;
    bus.b_req = 1'b0;
    rst = 1'b1;
    tick();
    check("idle_a_gnt", int'(bus.a_gnt), 0);

    // Single placement then render with exact 2-cycle latency
    write(1'b0, 2, 3, 7, "a_place");
    h_cnt = 10'd0; v_cnt = 10'd0; valid = 1'b0;
    tick(); tick();
    h_cnt = 10'd252; v_cnt = 10'd115; valid = 1'b1;
    tick();
    check("lat1_en", int'(glyph_en), 0);
    tick();
    check("lat2_en", int'(glyph_en), 1);
    check("lat2_sel", int'(glyph_sel), 7);
    check("lat2_addr", int'(glyph_addr), 270);

    // Fill columns 0 and 8 of row 0, then sweep the vector table
    write(1'b0, 0, 0, 1, "a_c0");
    write(1'b1, 0, 8, 9, "b_c8");
    for (int i = 0; i < 10; i++) begin
      pix(vecs[i].h, vecs[i].v, vecs[i].vl, en, sel, addr);
      check($sformatf("vec%0d_en", i), en, vecs[i].en);
      check($sformatf("vec%0d_sel", i), sel, vecs[i].sel);
      check($sformatf("vec%0d_addr", i), addr, vecs[i].addr);
    end

    // Both requesters held: last grant was B, so A leads and they alternate
    bus.a_row = 4'd4; bus.a_col = 4'd4; bus.a_val = 4'd4; bus.a_req = 1'b1;
    bus.b_row = 4'd5; bus.b_col = 4'd5; bus.b_val = 4'd5; bus.b_req = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check($sformatf("rr%0d_a", i), int'(bus.a_gnt), (i % 2 == 0) ? 1 : 0);
      check($sformatf("rr%0d_b", i), int'(bus.b_gnt), (i % 2 == 0) ? 0 : 1);
    end
    bus.a_req = 1'b0;
    bus.b_req = 1'b0;
    tick();
    check_cell(4, 4, 4, "rr_cell44");
    check_cell(5, 5, 5, "rr_cell55");

    // Out-of-range requests are granted but must not touch the board
    write(1'b1, 9, 0, 5, "b_row9");
    write(1'b1, 2, 3, 12, "b_val12");
    write(1'b0, 1, 9, 3, "a_col9");
    check_cell(0, 0, 1, "oor_cell00");
    check_cell(2, 3, 7, "oor_cell23");
    check_cell(2, 0, 0, "oor_cell20");

    // Clear with A pending; a second clear pulse mid-sequence is ignored
    bus.a_row = 4'd6; bus.a_col = 4'd6; bus.a_val = 4'd3; bus.a_req = 1'b1;
    bus.clr_board = 1'b1;
    tick();
    check("clr_no_gnt", int'(bus.a_gnt), 0);
    check("clr_busy", int'(bus.busy), 1);
    bus.clr_board = 1'b0;
    busy_cnt = 1;
    gnt_during = 0;
    for (int k = 0; k < 200 && bus.busy; k++) begin
      bus.clr_board = (k == 40);
      tick();
      if (bus.busy) busy_cnt++;
      if (bus.a_gnt || bus.b_gnt) gnt_during++;
    end
    bus.clr_board = 1'b0;
    check("clr_busy_cycles", busy_cnt, 81);
    check("clr_gnt_during", gnt_during, 0);
    tick();
    check("clr_post_gnt", int'(bus.a_gnt), 1);
    bus.a_req = 1'b0;
    tick();
    check_cell(2, 3, 0, "clr_cell23");
    check_cell(0, 0, 0, "clr_cell00");
    check_cell(0, 8, 0, "clr_cell08");
    check_cell(4, 4, 0, "clr_cell44");
    check_cell(6, 6, 3, "clr_cell66");

    // Reset once the clear index reaches 40
    write(1'b0, 8, 8, 2, "a_c88");
    check_cell(8, 8, 2, "pre_cell88");
    bus.clr_board = 1'b1;
    tick();
    bus.clr_board = 1'b0;
    repeat (41) tick();
    check("mid_busy", int'(bus.busy), 1);
    check("mid_en88", int'(glyph_en), 1);
    bus.a_row = 4'd7; bus.a_col = 4'd7; bus.a_val = 4'd4; bus.a_req = 1'b1;
    rst = 1'b0;
    tick();
    check("mid_rst_busy", int'(bus.busy), 0);
    check("mid_rst_gnt", int'(bus.a_gnt), 0);
    check("mid_rst_en", int'(glyph_en), 0);
    check("mid_rst_sel", int'(glyph_sel), 0);
    rst = 1'b1;
    tick();
    check("post_rst_gnt", int'(bus.a_gnt), 1);
    check("post_rst_busy", int'(bus.busy), 0);
    bus.a_req = 1'b0;
    tick();
    check_cell(7, 7, 4, "post_rst_cell77");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
